// File: rtl/link_egress_buffer.sv
// Per-link egress buffer: validates router TLP framing, stores tagged words
// in a FIFO and drains them to the link transmitter over valid/ready.
// DEPTH must be a power of two and at least 4.
module link_egress_buffer #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned LINK_ID      = 0,
   parameter int unsigned READY_MARGIN = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [39:0] header_word,
   input  logic        header_valid,
   input  logic [39:0] payload_word,
   input  logic        payload_valid,
   output logic        buffer_ready,
   output logic [31:0] out_data,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  tlp_count,
   output logic        overflow_err,
   output logic        framing_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = 34;
   localparam int unsigned RW = 11;
   localparam logic [1:0]  LINK = 2'(LINK_ID);

   typedef enum logic [1:0] {IDLE, HDR1, HDR2, PAYLOAD} state_e;

   state_e          state_q, state_d;
   logic            has_pay_q, has_pay_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [7:0]      tlp_q;
   logic            ovf_q, ferr_q, ready_q;

   logic            push_req, push, pop, full, fr_err, tlp_done;
   logic [EW-1:0]   push_entry, head;
   logic [PW-1:0]   count, count_d;
   logic            ready_d;

   // Bits of the router words that carry no meaning for this block.
   logic            unused_bits;
   assign unused_bits = ^{payload_word[39:32], header_word[38:34]};

   // Ingress framing FSM: next state, push request and error detection.
   always_comb begin
      state_d    = state_q;
      has_pay_d  = has_pay_q;
      rem_d      = rem_q;
      push_req   = 1'b0;
      push_entry = '0;
      fr_err     = 1'b0;
      tlp_done   = 1'b0;
      if (header_valid && payload_valid) begin
         fr_err = 1'b1;
      end else if (header_valid) begin
         case (state_q)
            IDLE: begin
               if (header_word[39] && (header_word[33:32] == LINK)) begin
                  push_req   = 1'b1;
                  push_entry = {1'b1, 1'b0, header_word[31:0]};
                  has_pay_d  = header_word[30];
                  rem_d      = (header_word[9:0] == 10'd0) ? RW'(1024) : RW'(header_word[9:0]);
                  state_d    = HDR1;
               end else begin
                  fr_err = 1'b1;
               end
            end
            HDR1: begin
               if (header_word[39]) begin
                  fr_err  = 1'b1;
                  state_d = IDLE;
               end else begin
                  push_req   = 1'b1;
                  push_entry = {1'b0, 1'b0, header_word[31:0]};
                  state_d    = HDR2;
               end
            end
            HDR2: begin
               if (header_word[39]) begin
                  fr_err  = 1'b1;
                  state_d = IDLE;
               end else begin
                  push_req   = 1'b1;
                  push_entry = {1'b0, !has_pay_q, header_word[31:0]};
                  if (has_pay_q) begin
                     state_d = PAYLOAD;
                  end else begin
                     tlp_done = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
            PAYLOAD: begin
               // A header word during payload is always a violation; a new
               // first-header flag additionally abandons the current TLP.
               fr_err = 1'b1;
               if (header_word[39]) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (payload_valid) begin
         if (state_q == PAYLOAD) begin
            push_req   = 1'b1;
            push_entry = {1'b0, (rem_q == RW'(1)), payload_word[31:0]};
            rem_d      = rem_q - RW'(1);
            if (rem_q == RW'(1)) begin
               tlp_done = 1'b1;
               state_d  = IDLE;
            end
         end else begin
            fr_err = 1'b1;
         end
      end
   end

   // FIFO occupancy, push/pop qualification and next-cycle flow control.
   always_comb begin
      count   = wr_ptr_q - rd_ptr_q;
      full    = (count == PW'(DEPTH));
      pop     = (count != '0) && out_ready;
      push    = push_req && !full;
      count_d = count + PW'(push) - PW'(pop);
      ready_d = (32'(count_d) + READY_MARGIN) <= DEPTH;
   end

   // State, pointers, counters and sticky errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         has_pay_q <= 1'b0;
         rem_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         tlp_q     <= '0;
         ovf_q     <= 1'b0;
         ferr_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         has_pay_q <= has_pay_d;
         rem_q     <= rem_d;
         ready_q   <= ready_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         // A TLP counts only once its last word actually landed in the FIFO.
         if (tlp_done && push && (tlp_q != 8'hFF)) tlp_q <= tlp_q + 8'd1;
         if (push_req && full) ovf_q  <= 1'b1;
         if (fr_err)           ferr_q <= 1'b1;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
   end

   assign head         = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid    = (count != '0);
   assign out_data     = out_valid ? head[31:0] : '0;
   assign out_sop      = out_valid && head[33];
   assign out_eop      = out_valid && head[32];
   assign buffer_ready = ready_q;
   assign tlp_count    = tlp_q;
   assign overflow_err = ovf_q;
   assign framing_err  = ferr_q;

endmodule

// File: tb/tb_link_egress_buffer.sv
// Self-checking bench for link_egress_buffer: directed scenarios followed by
// constrained-random traffic, compared each cycle against a queue-based model.
module tb_link_egress_buffer;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned LINK_ID = 0;
   localparam int unsigned MARGIN  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [39:0] header_word, payload_word;
   logic        header_valid, payload_valid, out_ready;
   logic        buffer_ready, out_sop, out_eop, out_valid;
   logic [31:0] out_data;
   logic [7:0]  tlp_count;
   logic        overflow_err, framing_err;

   always #5 clk = ~clk;

   link_egress_buffer #(.DEPTH(DEPTH), .LINK_ID(LINK_ID), .READY_MARGIN(MARGIN)) dut (
      .clk(clk), .reset(reset),
      .header_word(header_word), .header_valid(header_valid),
      .payload_word(payload_word), .payload_valid(payload_valid),
      .buffer_ready(buffer_ready),
      .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_valid(out_valid), .out_ready(out_ready),
      .tlp_count(tlp_count), .overflow_err(overflow_err), .framing_err(framing_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Single comparison point for the whole bench.
   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue of {sop,eop,data}, TLP progress as counts.
   bit [33:0] mq[$];
   bit        m_in_tlp, m_has_pay, m_ovf, m_ferr, m_ready;
   int        m_hdr_seen, m_pay_left, m_tlp;

   task automatic model_step(bit rst, bit hv, bit [39:0] hw, bit pv, bit [39:0] pw, bit ordy);
      bit want, done, full, pop;
      bit [33:0] e;
      if (rst) begin
         mq.delete();
         m_in_tlp = 0; m_has_pay = 0; m_hdr_seen = 0; m_pay_left = 0;
         m_tlp = 0; m_ovf = 0; m_ferr = 0; m_ready = 0;
         return;
      end
      want = 0; done = 0; e = '0;
      if (hv && pv) begin
         m_ferr = 1;
      end else if (hv) begin
         if (!m_in_tlp) begin
            if (hw[39] && hw[33:32] == 2'(LINK_ID)) begin
               want = 1; e = {1'b1, 1'b0, hw[31:0]};
               m_in_tlp = 1; m_hdr_seen = 1; m_has_pay = hw[30];
               m_pay_left = (hw[9:0] == 0) ? 1024 : int'(hw[9:0]);
            end else begin
               m_ferr = 1;
            end
         end else if (hw[39]) begin
            m_ferr = 1; m_in_tlp = 0;
         end else if (m_hdr_seen < 3) begin
            m_hdr_seen++;
            want = 1;
            if (m_hdr_seen == 3 && !m_has_pay) begin
               e = {1'b0, 1'b1, hw[31:0]}; done = 1; m_in_tlp = 0;
            end else begin
               e = {1'b0, 1'b0, hw[31:0]};
            end
         end else begin
            m_ferr = 1;
         end
      end else if (pv) begin
         if (m_in_tlp && m_hdr_seen == 3) begin
            m_pay_left--;
            want = 1; e = {1'b0, (m_pay_left == 0), pw[31:0]};
            if (m_pay_left == 0) begin
               done = 1; m_in_tlp = 0;
            end
         end else begin
            m_ferr = 1;
         end
      end
      full = (mq.size() == int'(DEPTH));
      pop  = (mq.size() > 0) && ordy;
      if (want && full) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (want && !full) begin
         mq.push_back(e);
         if (done && m_tlp < 255) m_tlp++;
      end
      m_ready = (int'(DEPTH) - mq.size()) >= int'(MARGIN);
   endtask

   task automatic check_outputs();
      bit [33:0] h;
      check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         h = mq[0];
         check_eq("out_data", 64'(out_data), 64'(h[31:0]));
         check_eq("out_sop", 64'(out_sop), 64'(h[33]));
         check_eq("out_eop", 64'(out_eop), 64'(h[32]));
      end
      check_eq("buffer_ready", 64'(buffer_ready), 64'(m_ready));
      check_eq("tlp_count", 64'(tlp_count), 64'(m_tlp));
      check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
      check_eq("framing_err", 64'(framing_err), 64'(m_ferr));
   endtask

   // One clock: drive at the falling edge, advance the model, check at the next falling edge.
   task automatic cycle(bit rst, bit hv, bit [39:0] hw, bit pv, bit [39:0] pw, bit ordy);
      reset = rst; header_valid = hv; header_word = hw;
      payload_valid = pv; payload_word = pw; out_ready = ordy;
      model_step(rst, hv, hw, pv, pw, ordy);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(int n, bit ordy);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, ordy);
   endtask

   function automatic bit [39:0] mk_first(bit [1:0] link, bit has_pay, bit [9:0] len);
      return {1'b1, 5'b0, link, 1'b0, has_pay, 20'h0, len};
   endfunction

   // Send a complete well-formed TLP with concurrent drain setting ordy.
   task automatic send_tlp(bit has_pay, bit [9:0] len, int n_pay, bit ordy);
      cycle(0, 1, mk_first(2'(LINK_ID), has_pay, len), 0, '0, ordy);
      cycle(0, 1, 40'h21, 0, '0, ordy);
      cycle(0, 1, 40'h22, 0, '0, ordy);
      for (int i = 0; i < n_pay; i++) cycle(0, 0, '0, 1, 40'(i + 10), ordy);
   endtask

   initial begin
      bit [39:0] hw, pw;
      bit hv, pv, ordy, rst;
      int r, rdy_pct;

      reset = 1; header_valid = 0; payload_valid = 0; out_ready = 0;
      header_word = '0; payload_word = '0;
      @(negedge clk);
      cycle(1, 0, '0, 0, '0, 0);
      cycle(1, 0, '0, 0, '0, 0);
      check_eq("rst_out_data", 64'(out_data), 64'd0);
      check_eq("rst_ready", 64'(buffer_ready), 64'd0);
      check_eq("rst_tlp", 64'(tlp_count), 64'd0);
      cycle(0, 0, '0, 0, '0, 1);
      check_eq("ready_after_release", 64'(buffer_ready), 64'd1);

      // No-payload TLP.
      cycle(0, 1, 40'h80_0000_0000, 0, '0, 1);
      check_eq("t1_w0", 64'({out_sop, out_eop, out_data}), 64'({2'b10, 32'h0}));
      cycle(0, 1, 40'h11, 0, '0, 1);
      check_eq("t1_w1", 64'({out_sop, out_eop, out_data}), 64'({2'b00, 32'h11}));
      cycle(0, 1, 40'h22, 0, '0, 1);
      check_eq("t1_w2", 64'({out_sop, out_eop, out_data}), 64'({2'b01, 32'h22}));
      idle(3, 1);
      check_eq("t1_tlp", 64'(tlp_count), 64'd1);

      // TLP with three payload words.
      cycle(0, 1, mk_first(2'(LINK_ID), 1, 10'd3), 0, '0, 1);
      cycle(0, 1, 40'h21, 0, '0, 1);
      cycle(0, 1, 40'h22, 0, '0, 1);
      cycle(0, 0, '0, 1, 40'hFF_0000_000A, 1);
      cycle(0, 0, '0, 1, 40'hFF_0000_000B, 1);
      check_eq("t2_no_eop_b", 64'(out_eop), 64'd0);
      cycle(0, 0, '0, 1, 40'hFF_0000_000C, 1);
      check_eq("t2_eop_c", 64'({out_eop, out_data}), 64'({1'b1, 32'hC}));
      idle(3, 1);
      check_eq("t2_tlp", 64'(tlp_count), 64'd2);
      check_eq("t2_errs", 64'({overflow_err, framing_err}), 64'd0);

      // Length 0 means 1024 payload words.
      send_tlp(1, 10'd0, 1023, 1);
      check_eq("t5_tlp_pending", 64'(tlp_count), 64'd2);
      cycle(0, 0, '0, 1, 40'h3FF, 1);
      check_eq("t5_eop", 64'(out_eop), 64'd1);
      idle(3, 1);
      check_eq("t5_tlp", 64'(tlp_count), 64'd3);

      // Reset in the middle of a payload.
      send_tlp(1, 10'd3, 1, 0);
      cycle(1, 0, '0, 0, '0, 0);
      check_eq("t6_valid", 64'(out_valid), 64'd0);
      check_eq("t6_tlp", 64'(tlp_count), 64'd0);
      cycle(0, 0, '0, 0, '0, 0);
      check_eq("t6_ready", 64'(buffer_ready), 64'd1);

      // Fill with no drain: ready drops on the 15th word, 17th overflows.
      for (int i = 0; i < 20; i++) begin
         if (i == 0)      cycle(0, 1, mk_first(2'(LINK_ID), 1, 10'd17), 0, '0, 0);
         else if (i < 3)  cycle(0, 1, 40'(i), 0, '0, 0);
         else             cycle(0, 0, '0, 1, 40'(i), 0);
         if (i == 13) check_eq("t3_ready14", 64'(buffer_ready), 64'd1);
         if (i == 14) check_eq("t3_ready15", 64'(buffer_ready), 64'd0);
         if (i == 15) check_eq("t3_no_ovf16", 64'(overflow_err), 64'd0);
         if (i == 16) check_eq("t3_ovf17", 64'(overflow_err), 64'd1);
      end
      idle(DEPTH + 2, 1);
      check_eq("t3_drained", 64'(out_valid), 64'd0);

      // Framing fault then a clean TLP.
      cycle(0, 0, '0, 1, 40'h55, 1);
      check_eq("t4_ferr", 64'(framing_err), 64'd1);
      check_eq("t4_fifo", 64'(out_valid), 64'd0);
      send_tlp(0, 10'd0, 0, 1);
      idle(3, 1);
      check_eq("t4_tlp", 64'(tlp_count), 64'd1);

      // Constrained-random traffic biased toward legal framing.
      rdy_pct = 70;
      for (int c = 0; c < 6000; c++) begin
         if (c % 256 == 0) rdy_pct = (rdy_pct == 70) ? 25 : 70;
         r    = $urandom_range(0, 99);
         ordy = ($urandom_range(0, 99) < rdy_pct);
         rst  = ($urandom_range(0, 499) == 0);
         hw   = 40'({$urandom(), $urandom()});
         pw   = 40'({$urandom(), $urandom()});
         hv   = 0; pv = 0;
         if (!m_in_tlp) begin
            if (r < 50) begin
               hv = 1; hw[39] = 1; hw[33:32] = 2'(LINK_ID);
               hw[9:0] = 10'($urandom_range(1, 6));
            end else if (r < 55) begin
               hv = 1;
               if (r < 53) hw[39] = 0;
               else begin hw[39] = 1; hw[33:32] = 2'(LINK_ID + 1); end
            end else if (r < 58) begin
               pv = 1;
            end
         end else if (m_hdr_seen < 3) begin
            if (r < 60) begin hv = 1; hw[39] = 0; end
            else if (r < 63) begin hv = 1; hw[39] = 1; end
            else if (r < 65) pv = 1;
            else if (r < 67) begin hv = 1; pv = 1; end
         end else begin
            if (r < 65) pv = 1;
            else if (r < 67) hv = 1;
            else if (r < 69) begin hv = 1; pv = 1; end
         end
         cycle(rst, hv, hw, pv, pw, ordy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
